// File: rtl/net_activity_monitor_if.sv
// net_activity_monitor_if
// Purpose: groups the control, configuration and result signals of the
//          net activity monitor into one bundle.
// Signals:
//   I3028     monitored net (from the upstream trigger subcircuit)
//   start     one-cycle request to open a measurement window
//   abort     terminates an active window, wins over start
//   win_len   window length in cycles
//   rare_val  value of I3028 that counts as a rare hit
//   thresh    rare-hit alarm threshold, 0 disables the alarm
//   busy      window armed or monitoring
//   done      window finished, results stable
//   rare_cnt  saturating count of rare samples
//   tog_cnt   saturating count of I3028 transitions
//   alarm     sticky threshold alarm
// Modports: master drives requests/config, slave is the monitor itself.
interface net_activity_monitor_if;
    logic        I3028;
    logic        start;
    logic        abort;
    logic [15:0] win_len;
    logic        rare_val;
    logic [7:0]  thresh;
    logic        busy;
    logic        done;
    logic [7:0]  rare_cnt;
    logic [15:0] tog_cnt;
    logic        alarm;

    modport master (
        output I3028, start, abort, win_len, rare_val, thresh,
        input  busy, done, rare_cnt, tog_cnt, alarm
    );

    modport slave (
        input  I3028, start, abort, win_len, rare_val, thresh,
        output busy, done, rare_cnt, tog_cnt, alarm
    );
endinterface

// File: rtl/net_activity_monitor.sv
// net_activity_monitor
// Purpose: measures activity of a single net over a programmable window.
//          It counts how often the net sits at a chosen "rare" value and
//          how often it toggles, and raises a sticky alarm when the rare
//          count reaches a threshold.
// Ports:
//   I1470_clk  clock, all state changes on the rising edge
//   I1477_rst  synchronous active-low reset
//   bus        net_activity_monitor_if slave modport (control, config,
//              monitored net and registered results)
module net_activity_monitor (
    input logic                   I1470_clk,
    input logic                   I1477_rst,
    net_activity_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MONITOR,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] remaining;
    logic        prev;
    logic [15:0] len_q;
    logic        rare_q;
    logic [7:0]  thresh_q;

    logic        busy;
    logic        done;
    logic [7:0]  rare_cnt;
    logic [15:0] tog_cnt;
    logic        alarm;

    logic        start_ok;
    logic        hit;
    logic        toggled;
    logic [7:0]  rare_next;
    logic [15:0] tog_next;

    // Next counter values for a MONITOR sample; both counters stop at
    // all-ones instead of wrapping.
    always_comb begin
        start_ok  = bus.start && !bus.abort && (state == IDLE || state == DONE);
        hit       = (bus.I3028 == rare_q);
        toggled   = (bus.I3028 != prev);
        rare_next = rare_cnt;
        tog_next  = tog_cnt;
        if (hit && rare_cnt != 8'hFF) begin
            rare_next = rare_cnt + 8'd1;
        end
        if (toggled && tog_cnt != 16'hFFFF) begin
            tog_next = tog_cnt + 16'd1;
        end
    end

    // Window FSM. Priority: reset, accepted start, abort, normal sequencing.
    // busy/done are registered alongside the state so they track it exactly.
    always_ff @(posedge I1470_clk) begin
        if (!I1477_rst) begin
            state     <= IDLE;
            remaining <= 16'd0;
            prev      <= 1'b0;
            len_q     <= 16'd0;
            rare_q    <= 1'b0;
            thresh_q  <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rare_cnt  <= 8'd0;
            tog_cnt   <= 16'd0;
            alarm     <= 1'b0;
        end else if (start_ok) begin
            len_q    <= bus.win_len;
            rare_q   <= bus.rare_val;
            thresh_q <= bus.thresh;
            rare_cnt <= 8'd0;
            tog_cnt  <= 16'd0;
            alarm    <= 1'b0;
            if (bus.win_len == 16'd0) begin
                // An empty window completes immediately without arming.
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end else begin
                state <= ARM;
                busy  <= 1'b1;
                done  <= 1'b0;
            end
        end else if (bus.abort && state != IDLE) begin
            // Results are deliberately left in place for inspection.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ARM: begin
                    // The net value seen here is the reference for the
                    // first toggle comparison.
                    remaining <= len_q;
                    prev      <= bus.I3028;
                    state     <= MONITOR;
                end
                MONITOR: begin
                    rare_cnt  <= rare_next;
                    tog_cnt   <= tog_next;
                    prev      <= bus.I3028;
                    remaining <= remaining - 16'd1;
                    // Comparing the next value lets alarm rise together
                    // with the count that reaches the threshold.
                    if (thresh_q != 8'd0 && rare_next == thresh_q) begin
                        alarm <= 1'b1;
                    end
                    if (remaining == 16'd1) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.rare_cnt = rare_cnt;
    assign bus.tog_cnt  = tog_cnt;
    assign bus.alarm    = alarm;

endmodule

// File: doc/net_activity_monitor.md
NET_ACTIVITY_MONITOR -- requirements
Module: net_activity_monitor

Interface
REQ-001 I1470_clk  input  1  single clock; all state updates on rising edge.
REQ-002 I1477_rst  input  1  synchronous, active-low reset; sampled on rising edge of I1470_clk.
REQ-003 I3028  input  1  monitored net; output of the upstream trigger subcircuit.
REQ-004 start  input  1  one-cycle request to begin a measurement window.
REQ-005 abort  input  1  terminates an active window; priority over start.
REQ-006 win_len  input  16  window length in cycles; latched on accepted start.
REQ-007 rare_val  input  1  value of I3028 counted as rare; latched on accepted start.
REQ-008 thresh  input  8  rare-hit alarm threshold; latched on accepted start; 0 disables the alarm.
REQ-009 busy  output  1  high in ARM and MONITOR.
REQ-010 done  output  1  high in DONE; held until the next accepted start, abort or reset.
REQ-011 rare_cnt  output  8  count of sampled cycles with I3028 == rare_val; saturates at 255.
REQ-012 tog_cnt  output  16  count of I3028 transitions inside the window; saturates at 65535.
REQ-013 alarm  output  1  sticky; set when rare_cnt reaches a nonzero thresh.

Function
REQ-014 FSM states: IDLE, ARM, MONITOR, DONE; encoding is free.
REQ-015 Start is accepted only in IDLE or DONE with abort low; start in ARM or MONITOR is ignored.
REQ-016 Accepted start: latch win_len, rare_val and thresh; clear rare_cnt, tog_cnt and alarm; go to DONE if win_len == 0, else to ARM.
REQ-017 ARM lasts exactly 1 cycle: load remaining <= latched win_len and prev <= I3028; no counting; next state MONITOR.
REQ-018 MONITOR, each cycle: sample I3028; rare_cnt++ if sample == rare_val; tog_cnt++ if sample != prev; prev <= sample; remaining--.
REQ-019 MONITOR samples exactly win_len cycles; the cycle in which remaining == 1 is the last sample, and the next state is DONE.
REQ-020 done rises the cycle after the last sample; counter values are final and stable in that cycle.
REQ-021 The ARM-captured prev is the toggle reference: a change between the ARM sample and the first MONITOR sample counts as a toggle.
REQ-022 Counters saturate and never wrap; saturation does not affect the window length.
REQ-023 With thresh != 0, alarm is set in the same cycle rare_cnt first equals thresh (registered together); it stays set until the next accepted start or reset.
REQ-024 With thresh > 255 unreachable by saturation, thresh == 255 alarms on the 255th hit.
REQ-025 Abort high in ARM, MONITOR or DONE: next state IDLE; counters and alarm hold their values; done = 0; busy = 0.
REQ-026 Start and abort in the same cycle: abort wins; start is dropped.
REQ-027 A new start accepted in DONE restarts cleanly per REQ-016, with no extra idle cycle.
REQ-028 Outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-029 With I1477_rst low at a rising edge, all of the following take effect: state IDLE; rare_cnt = 0; tog_cnt = 0; alarm = 0; done = 0; busy = 0; remaining = 0; prev = 0; latched configuration = 0.
REQ-030 Reset asserted mid-window overrides start, abort and counting in that cycle.
REQ-031 The first start can be accepted in the first cycle with I1477_rst high.

Verification
REQ-032 win_len = 4, rare_val = 1, thresh = 0; I3028 = 0 in ARM, then 1,1,0,1 in MONITOR -> done 6 cycles after start; rare_cnt = 3; tog_cnt = 3; alarm = 0.
REQ-033 win_len = 10, rare_val = 1, thresh = 2; I3028 = 1 constant -> alarm rises on the 2nd MONITOR cycle and stays high; final rare_cnt = 10; tog_cnt = 0.
REQ-034 win_len = 300, rare_val = 0, I3028 = 0 constant -> rare_cnt saturates at 255; done asserts after exactly 300 MONITOR cycles.
REQ-035 win_len = 0 -> done in the cycle after start; busy never rises; all counts = 0.
REQ-036 Start and abort together in IDLE -> state stays IDLE. Abort on the 3rd MONITOR cycle -> IDLE next cycle, counts frozen at 2-sample values.
REQ-037 I1477_rst low on the 5th MONITOR cycle of win_len = 8 -> all outputs 0 next cycle. Start issued on the first cycle after reset -> accepted.
